// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - shared state, opcode and datapath-select encodings for the control FSM
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } ctrl_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
    localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_SRC_A_RD1   = 2'b10;

    localparam logic [1:0] ALU_SRC_B_RD2  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RESULT_SRC_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM    = 2'b01;
    localparam logic [1:0] RESULT_SRC_ALU    = 2'b10;

    // States that stall on the memory handshake and are covered by the timeout
    function automatic logic is_mem_wait(input ctrl_state_e s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control bundle between the FSM and the datapath (optional instret under CTRL_RETIRE_CNT_EN)
interface multicycle_ctrl_fsm_if;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        adr_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [1:0]  aluop;
    logic        trap;
    logic [3:0]  state_o;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] instret;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
        output alu_src_a, alu_src_b, result_src, aluop, trap, state_o
`ifdef CTRL_RETIRE_CNT_EN
        , output instret
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
        input  alu_src_a, alu_src_b, result_src, aluop, trap, state_o
`ifdef CTRL_RETIRE_CNT_EN
        , input instret
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_timeout.sv
// rtl/multicycle_ctrl_fsm_timeout.sv - consecutive memory-wait counter with expiry flag
module ctrl_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_en,
    input  logic mem_ready,
    input  logic state_change,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // Count stalled cycles; any state change opens a fresh window
    always_ff @(posedge clk) begin
        if (rst || state_change) begin
            count <= '0;
        end else if (wait_en && !mem_ready) begin
            count <= count + 1'b1;
        end
    end

    // Expiry only on a stalled cycle, so a late mem_ready still wins; zero disables
    assign expired = (TIMEOUT_CYCLES != 0) && wait_en && !mem_ready
                     && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32I main control FSM (optional CTRL_RETIRE_CNT_EN retire counter)
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_ctrl_fsm_if.master   ctrl
);
    ctrl_state_e state;
    ctrl_state_e next_state;
    logic        expired;
    logic        wait_en;
    logic        trap_q;

    assign wait_en = is_mem_wait(state);

    ctrl_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .wait_en      (wait_en),
        .mem_ready    (ctrl.mem_ready),
        .state_change (next_state != state),
        .expired      (expired)
    );

    // Next-state selection; reset overrides everything and returns to FETCH
    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (ctrl.mem_ready) next_state = DECODE;
                      else if (expired)   next_state = TRAP;
            DECODE: begin
                case (ctrl.opcode)
                    OPC_LOAD, OPC_STORE: next_state = MEMADR;
                    OPC_RTYPE:           next_state = EXECR;
                    OPC_ITYPE:           next_state = EXECI;
                    OPC_JAL:             next_state = JAL;
                    OPC_BRANCH:          next_state = BEQ;
                    default:             next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = ctrl.opcode[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (ctrl.mem_ready) next_state = MEMWB;
                      else if (expired)   next_state = TRAP;
            MEMWB:    next_state = FETCH;
            MEMWRITE: if (ctrl.mem_ready) next_state = FETCH;
                      else if (expired)   next_state = TRAP;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
            TRAP:     next_state = TRAP;
            default:  next_state = TRAP;
        endcase
        if (rst) next_state = FETCH;
    end

    // State register and sticky trap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            trap_q <= 1'b0;
        end else begin
            state  <= next_state;
            if (next_state == TRAP) trap_q <= 1'b1;
        end
    end

    // Datapath controls decoded from state, with the FETCH/BEQ Mealy terms
    always_comb begin
        ctrl.pc_write   = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.adr_src    = 1'b0;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.alu_src_a  = ALU_SRC_A_PC;
        ctrl.alu_src_b  = ALU_SRC_B_RD2;
        ctrl.result_src = RESULT_SRC_ALUOUT;
        ctrl.aluop      = ALUOP_ADD;
        case (state)
            FETCH: begin
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_b  = ALU_SRC_B_FOUR;
                ctrl.result_src = RESULT_SRC_ALU;
                ctrl.ir_write   = ctrl.mem_ready;
                ctrl.pc_write   = ctrl.mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a = ALU_SRC_A_OLDPC;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            MEMADR: begin
                ctrl.alu_src_a = ALU_SRC_A_RD1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            MEMREAD: begin
                ctrl.adr_src  = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RESULT_SRC_MEM;
                ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            EXECR: begin
                ctrl.alu_src_a = ALU_SRC_A_RD1;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            EXECI: begin
                ctrl.alu_src_a = ALU_SRC_A_RD1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            ALUWB: ctrl.reg_write = 1'b1;
            BEQ: begin
                ctrl.alu_src_a = ALU_SRC_A_RD1;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.pc_write  = ctrl.zero;
            end
            JAL: begin
                ctrl.alu_src_a = ALU_SRC_A_OLDPC;
                ctrl.alu_src_b = ALU_SRC_B_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.reg_write = 1'b0;
        end
    end

    assign ctrl.trap    = trap_q;
    assign ctrl.state_o = state;

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] instret_q;

    // One retire per completed instruction, counted on the final step back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 32'd0;
        end else if (next_state == FETCH &&
                     (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ)) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign ctrl.instret = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - vector table, corner sequences and random model check for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if ifc();

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifc)
    );

    int n_pass = 0;
    int n_total = 0;

    localparam logic [14:0] EN_MASK = 15'h6E00;

    logic [14:0] ctl_now;
    assign ctl_now = {ifc.pc_write, ifc.ir_write, ifc.adr_src, ifc.mem_read, ifc.mem_write,
                      ifc.reg_write, ifc.alu_src_a, ifc.alu_src_b, ifc.result_src, ifc.aluop, ifc.trap};

    typedef struct {
        logic        r;
        logic [6:0]  opc;
        logic        z;
        logic        mr;
        ctrl_state_e st;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[$];

    logic [14:0] F1, F0, DEC, MA, MRD, MWB, MWR, ER, EI, AWB, B1, B0, JJ, TR;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [14:0] c(input logic pcw, input logic irw, input logic adr,
                                      input logic mrd, input logic mwr, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic [1:0] op, input logic tr);
        return {pcw, irw, adr, mrd, mwr, rw, a, b, rs, op, tr};
    endfunction

    function automatic vec_t mk(input logic r, input logic [6:0] opc, input logic z, input logic mr,
                                input ctrl_state_e st, input logic [14:0] ctl);
        vec_t v;
        v.r = r; v.opc = opc; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [6:0] opc, input logic z, input logic mr);
        @(negedge clk);
        rst = r;
        ifc.opcode = opc;
        ifc.zero = z;
        ifc.mem_ready = mr;
        #1;
    endtask

    // Spec output table, indexed by phase, for the random model
    function automatic logic [14:0] exp_ctl(input ctrl_state_e ph, input logic z, input logic mr);
        case (ph)
            FETCH:    return mr ? F1 : F0;
            DECODE:   return DEC;
            MEMADR:   return MA;
            MEMREAD:  return MRD;
            MEMWB:    return MWB;
            MEMWRITE: return MWR;
            EXECR:    return ER;
            EXECI:    return EI;
            ALUWB:    return AWB;
            BEQ:      return z ? B1 : B0;
            JAL:      return JJ;
            default:  return TR;
        endcase
    endfunction

    initial begin
        logic [6:0] R_, I_, L_, S_, B_, J_, X_;
        R_ = OPC_RTYPE; I_ = OPC_ITYPE; L_ = OPC_LOAD; S_ = OPC_STORE;
        B_ = OPC_BRANCH; J_ = OPC_JAL; X_ = 7'b0000000;

        F1  = c(1,1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 0);
        F0  = c(0,0,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 0);
        DEC = c(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0);
        MA  = c(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0);
        MRD = c(0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        MWB = c(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 0);
        MWR = c(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0);
        ER  = c(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 0);
        EI  = c(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10, 0);
        AWB = c(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
        B1  = c(1,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 0);
        B0  = c(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 0);
        JJ  = c(1,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0);
        TR  = c(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1);

        ifc.opcode = 7'd0; ifc.zero = 1'b0; ifc.mem_ready = 1'b0;

        // R-type
        vecs.push_back(mk(1, R_, 0, 1, FETCH, 15'd0));
        vecs.push_back(mk(0, R_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, R_, 0, 1, DECODE, DEC));
        vecs.push_back(mk(0, R_, 0, 1, EXECR, ER));
        vecs.push_back(mk(0, R_, 0, 1, ALUWB, AWB));
        // lw with three wait cycles
        vecs.push_back(mk(0, L_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, L_, 0, 1, DECODE, DEC));
        vecs.push_back(mk(0, L_, 0, 1, MEMADR, MA));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, L_, 0, 0, MEMREAD, MRD));
        vecs.push_back(mk(0, L_, 0, 1, MEMREAD, MRD));
        vecs.push_back(mk(0, L_, 0, 1, MEMWB, MWB));
        // beq taken, then not taken
        vecs.push_back(mk(0, B_, 1, 0, FETCH, F0));
        vecs.push_back(mk(0, B_, 1, 1, FETCH, F1));
        vecs.push_back(mk(0, B_, 1, 1, DECODE, DEC));
        vecs.push_back(mk(0, B_, 1, 1, BEQ, B1));
        vecs.push_back(mk(0, B_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, B_, 0, 1, DECODE, DEC));
        vecs.push_back(mk(0, B_, 0, 1, BEQ, B0));
        // jal, I-type, sw
        vecs.push_back(mk(0, J_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, J_, 0, 1, DECODE, DEC));
        vecs.push_back(mk(0, J_, 0, 1, JAL, JJ));
        vecs.push_back(mk(0, J_, 0, 1, ALUWB, AWB));
        vecs.push_back(mk(0, I_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, I_, 0, 1, DECODE, DEC));
        vecs.push_back(mk(0, I_, 0, 1, EXECI, EI));
        vecs.push_back(mk(0, I_, 0, 1, ALUWB, AWB));
        vecs.push_back(mk(0, S_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, S_, 0, 1, DECODE, DEC));
        vecs.push_back(mk(0, S_, 0, 1, MEMADR, MA));
        vecs.push_back(mk(0, S_, 0, 0, MEMWRITE, MWR));
        vecs.push_back(mk(0, S_, 0, 1, MEMWRITE, MWR));
        // illegal opcode traps and stays trapped until reset
        vecs.push_back(mk(0, X_, 0, 1, FETCH, F1));
        vecs.push_back(mk(0, X_, 0, 1, DECODE, DEC));
        for (int k = 0; k < 10; k++) vecs.push_back(mk(0, X_, k[0], k[1], TRAP, TR));
        vecs.push_back(mk(1, X_, 0, 1, FETCH, 15'd0));
        vecs.push_back(mk(0, R_, 0, 1, FETCH, F1));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].opc, vecs[i].z, vecs[i].mr);
            if (vecs[i].r) begin
                check($sformatf("vec%0d en", i), 32'(ctl_now & EN_MASK), 32'(vecs[i].ctl & EN_MASK));
            end else begin
                check($sformatf("vec%0d state", i), 32'(ifc.state_o), 32'(vecs[i].st));
                check($sformatf("vec%0d ctl", i), 32'(ctl_now), 32'(vecs[i].ctl));
            end
        end

        // Fetch timeout: 16 stalled cycles then TRAP
        drive(1, R_, 0, 0);
        for (int k = 0; k < 16; k++) begin
            drive(0, R_, 0, 0);
            check($sformatf("t5 wait%0d", k), 32'(ifc.state_o), 32'(FETCH));
        end
        drive(0, R_, 0, 0);
        check("t5 trap state", 32'(ifc.state_o), 32'(TRAP));
        check("t5 trap flag", 32'(ifc.trap), 32'd1);
        // mem_ready on the 16th cycle wins over the timeout
        drive(1, R_, 0, 0);
        for (int k = 0; k < 15; k++) drive(0, R_, 0, 0);
        drive(0, R_, 0, 1);
        check("t5 late ready ir_write", 32'(ifc.ir_write), 32'd1);
        drive(0, R_, 0, 1);
        check("t5 late ready state", 32'(ifc.state_o), 32'(DECODE));

        // Reset during a store access
        drive(1, S_, 0, 1);
        drive(0, S_, 0, 1);
        drive(0, S_, 0, 1);
        drive(0, S_, 0, 1);
        drive(0, S_, 0, 0);
        check("t6 mem_write before rst", 32'(ifc.mem_write), 32'd1);
        drive(1, S_, 0, 0);
        check("t6 mem_write in rst", 32'(ifc.mem_write), 32'd0);
        drive(0, S_, 0, 0);
        check("t6 state after rst", 32'(ifc.state_o), 32'(FETCH));
`ifdef CTRL_RETIRE_CNT_EN
        drive(1, S_, 0, 1);
        drive(0, S_, 0, 1);
        check("t6 instret reset", ifc.instret, 32'd0);
        drive(0, S_, 0, 1); drive(0, S_, 0, 1); drive(0, S_, 0, 1);
        drive(0, J_, 0, 1);
        check("t6 instret sw", ifc.instret, 32'd1);
        drive(0, J_, 0, 1); drive(0, J_, 0, 1); drive(0, J_, 0, 1);
        check("t6 instret mid jal", ifc.instret, 32'd1);
        drive(0, J_, 0, 1);
        check("t6 instret jal", ifc.instret, 32'd2);
`endif

        // Random instruction stream against a phase-queue model
        begin
            ctrl_state_e ph;
            ctrl_state_e plan[$];
            int wcnt, tcnt, stall;
            logic [31:0] m_ret;
            logic [6:0] cur_opc;
            drive(1, R_, 0, 1);
            ph = FETCH; wcnt = 0; tcnt = 0; stall = 0; m_ret = 0; cur_opc = R_;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic r, z, mr;
                r = ($urandom_range(0, 299) == 0) || (ph == TRAP && tcnt >= 4);
                if (ph == FETCH) begin
                    case ($urandom_range(0, 12))
                        0, 1:   cur_opc = R_;
                        2, 3:   cur_opc = I_;
                        4, 5:   cur_opc = L_;
                        6, 7:   cur_opc = S_;
                        8, 9:   cur_opc = B_;
                        10, 11: cur_opc = J_;
                        default: cur_opc = 7'b1110011;
                    endcase
                end
                if (stall == 0 && $urandom_range(0, 60) == 0) stall = $urandom_range(14, 18);
                z = 1'($urandom);
                mr = (stall > 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
                if (stall > 0) stall--;
                drive(r, cur_opc, z, mr);
                if (r) begin
                    check($sformatf("rnd%0d en", cyc), 32'(ctl_now & EN_MASK), 32'd0);
                end else begin
                    check($sformatf("rnd%0d st/ctl", cyc), {13'd0, ifc.state_o, ctl_now},
                          {13'd0, 4'(ph), exp_ctl(ph, z, mr)});
`ifdef CTRL_RETIRE_CNT_EN
                    check($sformatf("rnd%0d instret", cyc), ifc.instret, m_ret);
`endif
                end
                if (r) begin
                    ph = FETCH; plan.delete(); wcnt = 0; tcnt = 0; m_ret = 0;
                end else if (ph == TRAP) begin
                    tcnt++;
                end else if ((ph == FETCH || ph == MEMREAD || ph == MEMWRITE) && !mr) begin
                    wcnt++;
                    if (wcnt == 16) begin ph = TRAP; wcnt = 0; end
                end else begin
                    wcnt = 0;
                    if (ph == FETCH) begin
                        ph = DECODE;
                    end else begin
                        if (ph == DECODE) begin
                            plan.delete();
                            if (cur_opc == R_)      begin plan.push_back(EXECR); plan.push_back(ALUWB); end
                            else if (cur_opc == I_) begin plan.push_back(EXECI); plan.push_back(ALUWB); end
                            else if (cur_opc == L_) begin plan.push_back(MEMADR); plan.push_back(MEMREAD); plan.push_back(MEMWB); end
                            else if (cur_opc == S_) begin plan.push_back(MEMADR); plan.push_back(MEMWRITE); end
                            else if (cur_opc == J_) begin plan.push_back(JAL); plan.push_back(ALUWB); end
                            else if (cur_opc == B_) plan.push_back(BEQ);
                            else plan.push_back(TRAP);
                        end
                        if (plan.size() > 0) ph = plan.pop_front();
                        else begin ph = FETCH; m_ret++; end
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
